// File: rtl/sram_axi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_slave_if
// Description : AXI4 slave-port bundle (AW, W, B, AR, R channels) between an
//               interconnect and sram_axi_slave. The slave modport is used by
//               the bridge; the master modport by whatever drives it.
// Ports       : AW/W/AR request channels and B/R response channels, all with
//               the _S suffix of the interconnect slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_axi_slave_if #(
    parameter int ID_W = 8
);
    // Write address channel
    logic [ID_W-1:0] AWID_S;
    logic [31:0]     AWADDR_S;
    logic [3:0]      AWLEN_S;
    logic [2:0]      AWSIZE_S;
    logic [1:0]      AWBURST_S;
    logic            AWVALID_S;
    logic            AWREADY_S;
    // Write data channel
    logic [31:0]     WDATA_S;
    logic [3:0]      WSTRB_S;
    logic            WLAST_S;
    logic            WVALID_S;
    logic            WREADY_S;
    // Write response channel
    logic [ID_W-1:0] BID_S;
    logic [1:0]      BRESP_S;
    logic            BVALID_S;
    logic            BREADY_S;
    // Read address channel
    logic [ID_W-1:0] ARID_S;
    logic [31:0]     ARADDR_S;
    logic [3:0]      ARLEN_S;
    logic [2:0]      ARSIZE_S;
    logic [1:0]      ARBURST_S;
    logic            ARVALID_S;
    logic            ARREADY_S;
    // Read data channel
    logic [ID_W-1:0] RID_S;
    logic [31:0]     RDATA_S;
    logic [1:0]      RRESP_S;
    logic            RLAST_S;
    logic            RVALID_S;
    logic            RREADY_S;

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S
    );

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S
    );
endinterface
`default_nettype wire

// File: rtl/sram_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_slave
// Description : AXI4 slave bridging one interconnect port to a single-port
//               synchronous SRAM macro. One transaction in flight at a time;
//               write address wins over read address when both arrive together.
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               s_axi     - AXI4 slave channels (sram_axi_slave_if.slave)
//               CS, OE    - SRAM chip select / output enable (active high)
//               WEB       - SRAM byte write enables (active low)
//               A, DI     - SRAM word address / write data
//               DO        - SRAM read data (valid the cycle after CS&OE)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 14
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sram_axi_slave_if.slave        s_axi,
    output logic                   CS,
    output logic                   OE,
    output logic [3:0]             WEB,
    output logic [ADDR_W-1:0]      A,
    output logic [31:0]            DI,
    input  wire logic [31:0]       DO
);

    localparam logic [ADDR_W-1:0] c_ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        c_BURST_FIXED = 2'b00;
    localparam logic [1:0]        c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]        c_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_R_FETCH = 3'd1,
        S_R_DATA  = 3'd2,
        S_W_DATA  = 3'd3,
        S_W_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_len;
    logic [1:0]          r_burst;
    logic [3:0]          r_cnt;
    logic                r_err;

    logic                w_aw_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_w_beat;
    logic                w_beat_last;
    logic                w_err_set;
    logic [ADDR_W-1:0]   w_addr_adv;

    // Size and the byte-offset / out-of-range address bits carry no meaning
    // for a 32-bit word SRAM; fold them into a sink so they are consciously dropped.
    logic                w_unused_ok;
    assign w_unused_ok = &{1'b0, s_axi.AWSIZE_S, s_axi.ARSIZE_S,
                           s_axi.AWADDR_S[31:ADDR_W+2], s_axi.AWADDR_S[1:0],
                           s_axi.ARADDR_S[31:ADDR_W+2], s_axi.ARADDR_S[1:0]};

    // Write address always wins a same-cycle collision in IDLE.
    assign w_aw_hs     = (r_state == S_IDLE) && s_axi.AWVALID_S;
    assign w_ar_hs     = (r_state == S_IDLE) && s_axi.ARVALID_S && !s_axi.AWVALID_S;
    assign w_r_hs      = (r_state == S_R_DATA) && s_axi.RREADY_S;
    assign w_w_beat    = (r_state == S_W_DATA) && s_axi.WVALID_S;
    assign w_beat_last = (r_cnt == r_len);

    // A write beat is in error when WLAST disagrees with the beat count:
    // missing on the final beat, or asserted before it.
    assign w_err_set   = w_beat_last != s_axi.WLAST_S;

    // FIXED holds the address; INCR and WRAP (handled as INCR) step by one word
    // and roll over at the top of the SRAM.
    assign w_addr_adv  = (r_burst == c_BURST_FIXED) ? r_addr : r_addr + c_ADDR_ONE;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Transaction context: ID, address, length, burst type, beat count, error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_aw_hs) begin
            r_id    <= s_axi.AWID_S;
            r_addr  <= s_axi.AWADDR_S[ADDR_W+1:2];
            r_len   <= s_axi.AWLEN_S;
            r_burst <= s_axi.AWBURST_S;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_ar_hs) begin
            r_id    <= s_axi.ARID_S;
            r_addr  <= s_axi.ARADDR_S[ADDR_W+1:2];
            r_len   <= s_axi.ARLEN_S;
            r_burst <= s_axi.ARBURST_S;
            r_cnt   <= '0;
        end else if (w_r_hs) begin
            if (!w_beat_last) begin
                r_cnt  <= r_cnt + 4'd1;
                r_addr <= w_addr_adv;
            end
        end else if (w_w_beat) begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (!w_beat_last && !s_axi.WLAST_S) begin
                r_cnt  <= r_cnt + 4'd1;
                r_addr <= w_addr_adv;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and all channel / SRAM outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        s_axi.AWREADY_S = 1'b0;
        s_axi.ARREADY_S = 1'b0;
        s_axi.WREADY_S  = 1'b0;
        s_axi.BVALID_S  = 1'b0;
        s_axi.BID_S     = '0;
        s_axi.BRESP_S   = c_RESP_OKAY;
        s_axi.RVALID_S  = 1'b0;
        s_axi.RID_S     = '0;
        s_axi.RDATA_S   = '0;
        s_axi.RRESP_S   = c_RESP_OKAY;
        s_axi.RLAST_S   = 1'b0;
        CS              = 1'b0;
        OE              = 1'b0;
        WEB             = 4'hF;
        A               = '0;
        DI              = '0;

        case (r_state)
            S_IDLE: begin
                s_axi.AWREADY_S = 1'b1;
                s_axi.ARREADY_S = !s_axi.AWVALID_S;
                if (s_axi.AWVALID_S) begin
                    w_state_nxt = S_W_DATA;
                end else if (s_axi.ARVALID_S) begin
                    w_state_nxt = S_R_FETCH;
                end
            end

            S_R_FETCH: begin
                CS          = 1'b1;
                OE          = 1'b1;
                A           = r_addr;
                w_state_nxt = S_R_DATA;
            end

            S_R_DATA: begin
                // Keep the read asserted on the same address so DO stays
                // stable for as long as the master stalls.
                CS             = 1'b1;
                OE             = 1'b1;
                A              = r_addr;
                s_axi.RVALID_S = 1'b1;
                s_axi.RDATA_S  = DO;
                s_axi.RID_S    = r_id;
                s_axi.RLAST_S  = w_beat_last;
                if (s_axi.RREADY_S) begin
                    w_state_nxt = w_beat_last ? S_IDLE : S_R_FETCH;
                end
            end

            S_W_DATA: begin
                s_axi.WREADY_S = 1'b1;
                if (s_axi.WVALID_S) begin
                    CS  = 1'b1;
                    WEB = ~s_axi.WSTRB_S;
                    A   = r_addr;
                    DI  = s_axi.WDATA_S;
                    if (w_beat_last || s_axi.WLAST_S) begin
                        w_state_nxt = S_W_RESP;
                    end
                end
            end

            S_W_RESP: begin
                s_axi.BVALID_S = 1'b1;
                s_axi.BID_S    = r_id;
                s_axi.BRESP_S  = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
                if (s_axi.BREADY_S) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
